// File: rtl/z80_mem_wait_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : z80_mem_wait_gen_if
//  Description : Bus bundle between the Z80 bus, the wait generator and the
//                RAM controller. The slave modport is the wait generator view;
//                the master modport is the view of whatever drives the Z80
//                strobes and answers memory requests.
//  Revision    : 1.0  initial release
// ============================================================================
interface z80_mem_wait_gen_if #(
  parameter int ADDR_W = 16
);
  // Z80 side
  logic              z80_mreq_n;
  logic              z80_rd_n;
  logic              z80_wr_n;
  logic [ADDR_W-1:0] z80_addr;
  logic [7:0]        z80_dout;
  logic [7:0]        z80_din;
  logic              ram_wait;

  // RAM controller side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  // Status
  logic              timeout_err;

  modport slave (
    input  z80_mreq_n, z80_rd_n, z80_wr_n, z80_addr, z80_dout,
    input  mem_ack, mem_rdata,
    output z80_din, ram_wait,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output timeout_err
  );

  modport master (
    output z80_mreq_n, z80_rd_n, z80_wr_n, z80_addr, z80_dout,
    output mem_ack, mem_rdata,
    input  z80_din, ram_wait,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/z80_mem_wait_gen.sv
`default_nettype none
// ============================================================================
//  Module      : z80_mem_wait_gen
//  Description : Memory-side responder for the Z80 bus. Each assertion of a
//                memory read/write strobe becomes exactly one req/ack
//                transaction towards the RAM controller, while ram_wait holds
//                the Z80 clock frozen until the access completes or times out.
//  Revision    : 1.0  initial release
// ============================================================================
module z80_mem_wait_gen #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255   // 1..1023 cycles waiting for mem_ack
) (
  input  wire                    clk,
  input  wire                    reset,
  z80_mem_wait_gen_if.slave      bus
);

  // Counter only needs to reach TIMEOUT-1; abort happens before any wrap.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_HOLD = 2'd2;

  logic [1:0]        r_state;
  logic              r_acc_q;
  logic [CW-1:0]     r_cnt;
  logic              r_ram_wait;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [7:0]        r_z80_din;
  logic              r_timeout_err;

  logic              w_acc;
  logic              w_start;

  // A real access needs MREQ plus RD or WR; refresh (MREQ only) never qualifies.
  // Only the rising edge of the qualified strobe starts a transaction.
  always_comb begin
    w_acc   = ~bus.z80_mreq_n & (~bus.z80_rd_n | ~bus.z80_wr_n);
    w_start = w_acc & ~r_acc_q;
  end

  // Access sequencer: IDLE -> WAIT (request outstanding) -> HOLD (until strobe release).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_ST_IDLE;
      r_acc_q       <= 1'b0;
      r_cnt         <= '0;
      r_ram_wait    <= 1'b1;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= 8'h00;
      r_z80_din     <= 8'hFF;
      r_timeout_err <= 1'b0;
    end else begin
      r_acc_q       <= w_acc;
      r_timeout_err <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_start) begin
            r_mem_addr  <= bus.z80_addr;
            r_mem_wdata <= bus.z80_dout;
            // RD and WR both low is resolved as a read.
            r_mem_we    <= ~bus.z80_wr_n & bus.z80_rd_n;
            r_mem_req   <= 1'b1;
            r_ram_wait  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          // Ack wins over a timeout landing in the same cycle.
          if (bus.mem_ack) begin
            r_mem_req  <= 1'b0;
            r_ram_wait <= 1'b1;
            if (!r_mem_we) begin
              r_z80_din <= bus.mem_rdata;
            end
            r_state <= c_ST_HOLD;
          end else if (r_cnt == c_CNT_LAST) begin
            r_mem_req     <= 1'b0;
            r_ram_wait    <= 1'b1;
            r_timeout_err <= 1'b1;
            if (!r_mem_we) begin
              r_z80_din <= 8'hFF;
            end
            r_state <= c_ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        c_ST_HOLD: begin
          // Z80 runs again; wait for the strobe to go away so one
          // assertion yields exactly one transaction.
          if (!w_acc) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          r_state    <= c_ST_IDLE;
          r_mem_req  <= 1'b0;
          r_ram_wait <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ram_wait    = r_ram_wait;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.z80_din     = r_z80_din;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_z80_mem_wait_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_mem_wait_gen
//  Description : Scoreboard bench for z80_mem_wait_gen. Scenario tasks push
//                the expected transaction when they drive the strobes; a bus
//                monitor collects completed transactions for comparison.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z80_mem_wait_gen;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [15:0] len;
    logic        err;
    logic [7:0]  din;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z80_mem_wait_gen_if #(.ADDR_W(ADDR_W)) bus ();

  z80_mem_wait_gen #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   stab_err    = 0;
  int   n_req       = 0;
  int   n_err       = 0;
  txn_t exp_q[$];
  txn_t obs_q[$];
  logic [7:0] exp_din;
  txn_t cur;
  bit   in_req = 1'b0;

  // Bus monitor: records each request window and checks invariants per cycle.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      in_req = 1'b0;
    end else begin
      if (bus.ram_wait !== !bus.mem_req) stab_err++;
      if (bus.timeout_err === 1'b1) n_err++;
      if (bus.mem_req === 1'b1 && !in_req) begin
        in_req    = 1'b1;
        cur       = '0;
        cur.addr  = bus.mem_addr;
        cur.we    = bus.mem_we;
        cur.wdata = bus.mem_wdata;
        cur.len   = 16'd1;
        n_req++;
      end else if (bus.mem_req === 1'b1) begin
        if (bus.mem_addr !== cur.addr || bus.mem_we !== cur.we || bus.mem_wdata !== cur.wdata)
          stab_err++;
        cur.len = cur.len + 16'd1;
      end else if (in_req) begin
        in_req  = 1'b0;
        cur.err = bus.timeout_err;
        cur.din = bus.z80_din;
        obs_q.push_back(cur);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic release_bus();
    bus.z80_mreq_n = 1'b1;
    bus.z80_rd_n   = 1'b1;
    bus.z80_wr_n   = 1'b1;
  endtask

  task automatic drive_strobe(input logic [15:0] a, input logic rd_n, input logic wr_n,
                              input logic [7:0] d);
    bus.z80_addr   = a;
    bus.z80_dout   = d;
    bus.z80_mreq_n = 1'b0;
    bus.z80_rd_n   = rd_n;
    bus.z80_wr_n   = wr_n;
  endtask

  // Ack sampled on the k-th rising edge after the strobe is first sampled.
  task automatic pulse_ack(input int k, input logic [7:0] rd);
    repeat (k) @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'($urandom);
  endtask

  task automatic push_exp(input logic [15:0] a, input logic we, input logic [7:0] d,
                          input int len, input logic err, input logic [7:0] rd);
    if (!we) exp_din = err ? 8'hFF : rd;
    exp_q.push_back(txn_t'{a, we, d, 16'(len), err, exp_din});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    release_bus();
    bus.z80_addr  = '0;
    bus.z80_dout  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    exp_din       = 8'hFF;
    repeat (3) @(negedge clk);
    vectors++; if (bus.ram_wait !== 1'b1) begin miscompares++; $display("FAIL reset_ram_wait: got %b want 1", bus.ram_wait); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    vectors++; if (bus.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata); end
    vectors++; if (bus.z80_din !== 8'hFF) begin miscompares++; $display("FAIL reset_z80_din: got %h want FF", bus.z80_din); end
    vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    txn_t e, o;
    drive_strobe(16'h1234, 1'b0, 1'b1, 8'h00);
    push_exp(16'h1234, 1'b0, 8'h00, 5, 1'b0, 8'hA5);
    pulse_ack(5, 8'hA5);
    release_bus();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL read_txn: got none, want addr=%h len=%0d", e.addr, e.len); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL read_txn: got addr=%h we=%b wd=%h len=%0d err=%b din=%h, want addr=%h we=%b wd=%h len=%0d err=%b din=%h", o.addr, o.we, o.wdata, o.len, o.err, o.din, e.addr, e.we, e.wdata, e.len, e.err, e.din); end
      end
    end
    vectors++; if (bus.z80_din !== 8'hA5) begin miscompares++; $display("FAIL read_din: got %h want A5", bus.z80_din); end
  endtask

  task automatic test_write();
    txn_t e, o;
    drive_strobe(16'hC000, 1'b1, 1'b0, 8'h3C);
    push_exp(16'hC000, 1'b1, 8'h3C, 1, 1'b0, 8'h00);
    pulse_ack(1, 8'hDE);
    release_bus();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL write_txn: got none, want addr=%h len=%0d", e.addr, e.len); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL write_txn: got addr=%h we=%b wd=%h len=%0d err=%b din=%h, want addr=%h we=%b wd=%h len=%0d err=%b din=%h", o.addr, o.we, o.wdata, o.len, o.err, o.din, e.addr, e.we, e.wdata, e.len, e.err, e.din); end
      end
    end
    vectors++; if (bus.z80_din !== exp_din) begin miscompares++; $display("FAIL write_din_kept: got %h want %h", bus.z80_din, exp_din); end
  endtask

  task automatic test_hold_refresh();
    txn_t e, o;
    int s;
    s = n_req;
    drive_strobe(16'h0042, 1'b0, 1'b1, 8'h00);
    push_exp(16'h0042, 1'b0, 8'h00, 3, 1'b0, 8'h11);
    pulse_ack(3, 8'h11);
    repeat (20) @(negedge clk);
    release_bus();
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL hold_txn: got none, want addr=%h len=%0d", e.addr, e.len); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL hold_txn: got addr=%h we=%b wd=%h len=%0d err=%b din=%h, want addr=%h we=%b wd=%h len=%0d err=%b din=%h", o.addr, o.we, o.wdata, o.len, o.err, o.din, e.addr, e.we, e.wdata, e.len, e.err, e.din); end
      end
    end
    vectors++; if (n_req - s != 1) begin miscompares++; $display("FAIL hold_single_req: got %0d requests want 1", n_req - s); end
    // Refresh: MREQ low with RD/WR high
    s = n_req;
    bus.z80_mreq_n = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (bus.ram_wait !== 1'b1) begin miscompares++; $display("FAIL refresh_ram_wait: got %b want 1", bus.ram_wait); end
    release_bus();
    repeat (2) @(negedge clk);
    vectors++; if (n_req != s || obs_q.size() != 0) begin miscompares++; $display("FAIL refresh_no_req: got %0d requests want 0", n_req - s); end
  endtask

  task automatic test_rd_wr_both();
    txn_t e, o;
    drive_strobe(16'h0ABC, 1'b0, 1'b0, 8'hEE);
    push_exp(16'h0ABC, 1'b0, 8'hEE, 2, 1'b0, 8'h42);
    pulse_ack(2, 8'h42);
    release_bus();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL rdwr_txn: got none, want addr=%h len=%0d", e.addr, e.len); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL rdwr_txn: got addr=%h we=%b wd=%h len=%0d err=%b din=%h, want addr=%h we=%b wd=%h len=%0d err=%b din=%h", o.addr, o.we, o.wdata, o.len, o.err, o.din, e.addr, e.we, e.wdata, e.len, e.err, e.din); end
      end
    end
  endtask

  task automatic test_timeout();
    txn_t e, o;
    int se;
    se = n_err;
    drive_strobe(16'h5555, 1'b0, 1'b1, 8'h00);
    push_exp(16'h5555, 1'b0, 8'h00, TIMEOUT, 1'b1, 8'h00);
    repeat (12) @(negedge clk);
    release_bus();
    repeat (2) @(negedge clk);
    // Ack arriving in the last allowed cycle completes normally.
    drive_strobe(16'h6666, 1'b0, 1'b1, 8'h00);
    push_exp(16'h6666, 1'b0, 8'h00, TIMEOUT, 1'b0, 8'h5A);
    pulse_ack(TIMEOUT, 8'h5A);
    release_bus();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL timeout_txn: got none, want addr=%h len=%0d", e.addr, e.len); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL timeout_txn: got addr=%h we=%b wd=%h len=%0d err=%b din=%h, want addr=%h we=%b wd=%h len=%0d err=%b din=%h", o.addr, o.we, o.wdata, o.len, o.err, o.din, e.addr, e.we, e.wdata, e.len, e.err, e.din); end
      end
    end
    vectors++; if (n_err - se != 1) begin miscompares++; $display("FAIL timeout_pulse: got %0d err cycles want 1", n_err - se); end
  endtask

  task automatic test_reset_mid();
    int s;
    s = n_req;
    drive_strobe(16'h7777, 1'b0, 1'b1, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    release_bus();
    exp_din = 8'hFF;
    @(posedge clk); #1;
    vectors++; if (bus.mem_req !== 1'b0 || bus.ram_wait !== 1'b1) begin miscompares++; $display("FAIL rstmid_bus: got req=%b wait=%b want req=0 wait=1", bus.mem_req, bus.ram_wait); end
    vectors++; if (bus.z80_din !== 8'hFF) begin miscompares++; $display("FAIL rstmid_din: got %h want FF", bus.z80_din); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.mem_req !== 1'b0 || bus.ram_wait !== 1'b1 || bus.z80_din !== 8'hFF) begin miscompares++; $display("FAIL stray_ack: got req=%b wait=%b din=%h want req=0 wait=1 din=FF", bus.mem_req, bus.ram_wait, bus.z80_din); end
    vectors++; if (n_req - s != 1 || obs_q.size() != 0) begin miscompares++; $display("FAIL stray_ack_txn: got %0d requests %0d completions want 1 and 0", n_req - s, obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    txn_t e, o;
    int s;
    s = n_req;
    drive_strobe(16'h0100, 1'b0, 1'b1, 8'h00);
    push_exp(16'h0100, 1'b0, 8'h00, 2, 1'b0, 8'h77);
    pulse_ack(2, 8'h77);
    release_bus();
    @(negedge clk);
    drive_strobe(16'h0200, 1'b1, 1'b0, 8'h99);
    push_exp(16'h0200, 1'b1, 8'h99, 3, 1'b0, 8'h00);
    pulse_ack(3, 8'h13);
    release_bus();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL b2b_txn: got none, want addr=%h len=%0d", e.addr, e.len); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL b2b_txn: got addr=%h we=%b wd=%h len=%0d err=%b din=%h, want addr=%h we=%b wd=%h len=%0d err=%b din=%h", o.addr, o.we, o.wdata, o.len, o.err, o.din, e.addr, e.we, e.wdata, e.len, e.err, e.din); end
      end
    end
    vectors++; if (n_req - s != 2) begin miscompares++; $display("FAIL b2b_count: got %0d requests want 2", n_req - s); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_hold_refresh();
    test_rd_wr_both();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (stab_err != 0) begin miscompares++; $display("FAIL bus_invariants: got %0d violations want 0", stab_err); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
